instruction_fetch_unit: RTL and testbench

- Fetch-stage requester that pairs with the 128-word instruction memory.
- Owns the program counter and drives the memory's 32-bit byte address; the memory responds combinationally with the 32-bit instruction in the same cycle.
- Captures instruction and PC+4 into the IF/ID pipeline register with a valid bit.
- Handles stall, flush and taken-branch redirect from later pipeline stages.

---
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 tb/tb_instruction_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and fills the IF/ID register.
// Optional fetch counter enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IMemAddress,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount
`endif
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_d;
  logic [31:0] ifid_instr_d;
  logic [31:0] ifid_pcplus4_d;
  logic        ifid_valid_d;
  logic        load_valid;
  logic        unused_target_bits;

  // Redirect targets are forced word-aligned, so the low bits never matter.
  assign unused_target_bits = ^BranchTarget[1:0];

  assign pc_plus4    = PC + 32'd4;
  assign IMemAddress = PC;

  always_comb begin
    pc_d           = PC;
    ifid_instr_d   = IFID_Instruction;
    ifid_pcplus4_d = IFID_PCPlus4;
    ifid_valid_d   = IFID_Valid;
    load_valid     = 1'b0;

    if (BranchTaken) begin
      // Redirect overrides stall; the instruction fetched this cycle is wrong-path.
      pc_d           = {BranchTarget[31:2], 2'b00};
      ifid_instr_d   = 32'd0;
      ifid_pcplus4_d = 32'd0;
      ifid_valid_d   = 1'b0;
    end else if (Stall) begin
      if (Flush) begin
        ifid_instr_d   = 32'd0;
        ifid_pcplus4_d = 32'd0;
        ifid_valid_d   = 1'b0;
      end
    end else begin
      pc_d = pc_plus4;
      if (Flush) begin
        ifid_instr_d   = 32'd0;
        ifid_pcplus4_d = 32'd0;
        ifid_valid_d   = 1'b0;
      end else begin
        ifid_instr_d   = IMemInstruction;
        ifid_pcplus4_d = pc_plus4;
        ifid_valid_d   = 1'b1;
        load_valid     = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PC               <= RESET_PC;
      IFID_Instruction <= 32'd0;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else begin
      PC               <= pc_d;
      IFID_Instruction <= ifid_instr_d;
      IFID_PCPlus4     <= ifid_pcplus4_d;
      IFID_Valid       <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FetchCount <= 32'd0;
    end else if (load_valid) begin
      FetchCount <= FetchCount + 32'd1;
    end
  end
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; memory[i] = i*3.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic [31:0] IMemInstruction;
  logic [31:0] IMemAddress;
  logic [31:0] PC;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [128];
  logic [6:0]  mem_idx;

  assign mem_idx         = IMemAddress[8:2];
  assign IMemInstruction = mem[mem_idx];

  always #5 Clk = ~Clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Stall            (Stall),
    .Flush            (Flush),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .IMemInstruction  (IMemInstruction),
    .IMemAddress      (IMemAddress),
    .PC               (PC),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount       (FetchCount)
`endif
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'd0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #3;
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
    checks++; if (IMemAddress !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want %h", IMemAddress, 32'h0); end
    checks++; if (IFID_Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", IFID_Instruction, 32'h0); end
    checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got %h want %h", IFID_PCPlus4, 32'h0); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want %b", IFID_Valid, 1'b0); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (FetchCount !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0d want %0d", FetchCount, 0); end
`endif
  endtask

  task automatic test_free_run();
    logic [31:0] exp_instr [4];
    logic [31:0] exp_pcp4  [4];
    exp_instr = '{32'd0, 32'd3, 32'd6, 32'd9};
    exp_pcp4  = '{32'd4, 32'd8, 32'd12, 32'd16};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (IFID_Instruction !== exp_instr[i]) begin errors++; $display("FAIL free_instr[%0d] got %0d want %0d", i, IFID_Instruction, exp_instr[i]); end
      checks++; if (IFID_PCPlus4 !== exp_pcp4[i]) begin errors++; $display("FAIL free_pcp4[%0d] got %0d want %0d", i, IFID_PCPlus4, exp_pcp4[i]); end
      checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL free_valid[%0d] got %b want 1", i, IFID_Valid); end
      checks++; if (PC !== exp_pcp4[i]) begin errors++; $display("FAIL free_pc[%0d] got %0d want %0d", i, PC, exp_pcp4[i]); end
    end
    checks++; if (IMemAddress !== 32'd16) begin errors++; $display("FAIL free_addr got %0d want 16", IMemAddress); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    checks++; if (PC !== 32'd8) begin errors++; $display("FAIL stall_pre_pc got %0d want 8", PC); end
    checks++; if (IFID_Instruction !== 32'd3) begin errors++; $display("FAIL stall_pre_instr got %0d want 3", IFID_Instruction); end
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (PC !== 32'd8) begin errors++; $display("FAIL stall_pc[%0d] got %0d want 8", i, PC); end
      checks++; if (IFID_Instruction !== 32'd3) begin errors++; $display("FAIL stall_instr[%0d] got %0d want 3", i, IFID_Instruction); end
      checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, IFID_Valid); end
      checks++; if (IFID_PCPlus4 !== 32'd8) begin errors++; $display("FAIL stall_pcp4[%0d] got %0d want 8", i, IFID_PCPlus4); end
    end
    Stall = 1'b0;
    step();
    checks++; if (IFID_Instruction !== 32'd6) begin errors++; $display("FAIL stall_rel_instr got %0d want 6", IFID_Instruction); end
    checks++; if (PC !== 32'd12) begin errors++; $display("FAIL stall_rel_pc got %0d want 12", PC); end
  endtask

  task automatic test_branch();
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    step();
    BranchTaken = 1'b0;
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL br_pc got %h want %h", PC, 32'h40); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b want 0", IFID_Valid); end
    checks++; if (IFID_Instruction !== 32'd0) begin errors++; $display("FAIL br_instr got %0d want 0", IFID_Instruction); end
    checks++; if (IFID_PCPlus4 !== 32'd0) begin errors++; $display("FAIL br_pcp4 got %0d want 0", IFID_PCPlus4); end
    step();
    checks++; if (IFID_Instruction !== 32'd48) begin errors++; $display("FAIL br_tgt_instr got %0d want 48", IFID_Instruction); end
    checks++; if (IFID_PCPlus4 !== 32'h44) begin errors++; $display("FAIL br_tgt_pcp4 got %h want %h", IFID_PCPlus4, 32'h44); end
    checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL br_tgt_valid got %b want 1", IFID_Valid); end
  endtask

  task automatic test_branch_over_stall();
    BranchTaken = 1'b1; Stall = 1'b1; BranchTarget = 32'h43;
    step();
    BranchTaken = 1'b0; Stall = 1'b0;
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL brst_pc got %h want %h", PC, 32'h40); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL brst_valid got %b want 0", IFID_Valid); end
    checks++; if (IFID_Instruction !== 32'd0) begin errors++; $display("FAIL brst_instr got %0d want 0", IFID_Instruction); end
    step();
    checks++; if (IFID_Instruction !== 32'd48) begin errors++; $display("FAIL brst_next_instr got %0d want 48", IFID_Instruction); end
    // stall with flush: PC holds, IF/ID becomes a bubble
    Stall = 1'b1; Flush = 1'b1;
    step();
    Stall = 1'b0; Flush = 1'b0;
    checks++; if (PC !== 32'h44) begin errors++; $display("FAIL stfl_pc got %h want %h", PC, 32'h44); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL stfl_valid got %b want 0", IFID_Valid); end
    checks++; if (IFID_PCPlus4 !== 32'd0) begin errors++; $display("FAIL stfl_pcp4 got %0d want 0", IFID_PCPlus4); end
  endtask

  task automatic test_flush_async_reset();
    do_reset();
    step(); step(); step();
    checks++; if (PC !== 32'd12) begin errors++; $display("FAIL fl_pre_pc got %0d want 12", PC); end
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    checks++; if (PC !== 32'd16) begin errors++; $display("FAIL fl_pc got %0d want 16", PC); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b want 0", IFID_Valid); end
    checks++; if (IFID_Instruction !== 32'd0) begin errors++; $display("FAIL fl_instr got %0d want 0", IFID_Instruction); end
    step();
    checks++; if (IFID_Instruction !== 32'd12) begin errors++; $display("FAIL fl_next_instr got %0d want 12", IFID_Instruction); end
    Stall = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (PC !== 32'd0) begin errors++; $display("FAIL ar_pc got %0d want 0", PC); end
    checks++; if (IFID_Instruction !== 32'd0) begin errors++; $display("FAIL ar_instr got %0d want 0", IFID_Instruction); end
    checks++; if (IFID_PCPlus4 !== 32'd0) begin errors++; $display("FAIL ar_pcp4 got %0d want 0", IFID_PCPlus4); end
    checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", IFID_Valid); end
    Stall = 1'b0;
    #1;
    Reset = 1'b0;
    step();
    checks++; if (IFID_Instruction !== 32'd0 || IFID_PCPlus4 !== 32'd4 || IFID_Valid !== 1'b1) begin
      errors++; $display("FAIL ar_first_fetch got %0d/%0d/%b want 0/4/1", IFID_Instruction, IFID_PCPlus4, IFID_Valid);
    end
  endtask

  task automatic test_wrap();
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    step();
    BranchTaken = 1'b0;
    checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_pc got %h want %h", PC, 32'hFFFF_FFFC); end
    step();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", PC, 32'h0); end
    checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 got %h want %h", IFID_PCPlus4, 32'h0); end
    // 0xFFFFFFFC aliases to memory word 127 -> 381
    checks++; if (IFID_Instruction !== 32'd381) begin errors++; $display("FAIL wrap_instr got %0d want 381", IFID_Instruction); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_count();
    do_reset();
    checks++; if (FetchCount !== 32'd0) begin errors++; $display("FAIL cnt_init got %0d want 0", FetchCount); end
    for (int i = 0; i < 10; i++) step();
    checks++; if (FetchCount !== 32'd10) begin errors++; $display("FAIL cnt_free got %0d want 10", FetchCount); end
    Stall = 1'b1;
    step();
    Stall = 1'b0;
    BranchTaken = 1'b1; BranchTarget = 32'h80;
    step();
    BranchTaken = 1'b0;
    checks++; if (FetchCount !== 32'd10) begin errors++; $display("FAIL cnt_final got %0d want 10", FetchCount); end
    step();
    checks++; if (FetchCount !== 32'd11) begin errors++; $display("FAIL cnt_resume got %0d want 11", FetchCount); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i * 3;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_flush_async_reset();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
